// File: rtl/adda_pkg.sv
// Shared types and frame constants for the ADC-to-DAC serial loopback controller.
// Frame words are built here so the top and the bench-facing docs agree on bit layout.
package adda_pkg;

    typedef enum logic [1:0] {
        GAP      = 2'd0,
        ADC_XFER = 2'd1,
        DAC_XFER = 2'd2
    } adda_state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int CSLD_TICKS = 33;
    localparam int TICK_W     = 6;

    // First SCK rising tick that carries an ADC data bit (bit 11 arrives after the 4 config bits).
    localparam int ADC_SAMPLE_FIRST = 2 * (FRAME_BITS - DATA_BITS) + 1;

    function automatic logic [FRAME_BITS-1:0] adc_frame_word(input logic [3:0] cfg);
        return {cfg, {DATA_BITS{1'b0}}};
    endfunction

    function automatic logic [FRAME_BITS-1:0] dac_frame_word(input logic [DATA_BITS-1:0] sample);
        return {{(FRAME_BITS - DATA_BITS){1'b0}}, sample};
    endfunction

endpackage

// File: rtl/adda_spi_engine.sv
// Tick generator and 16-bit SPI frame sequencer shared by the ADC and DAC ports.
// Pins for both ports are registered here; only the port latched at launch ever moves.
module adda_spi_engine
    import adda_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  port,
    input  logic [FRAME_BITS-1:0] tx_word,
    input  logic                  sdo,
    output logic                  tick,
    output logic                  done,
    output logic [DATA_BITS-1:0]  rx_word,
    output logic [1:0]            sck,
    output logic [1:0]            csld,
    output logic [1:0]            sdin
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0]      div_cnt_reg;
    logic [TICK_W-1:0]     t_reg;
    logic                  busy_reg;
    logic                  port_reg;
    logic [FRAME_BITS-1:0] tx_sh_reg;
    logic [DATA_BITS-1:0]  rx_sh_reg;

    logic launch;
    logic rise_t;
    logic fall_t;
    logic end_t;
    logic sample_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    assign tick = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

    // While busy, t_reg holds the index of the tick about to be executed (1..33).
    assign launch   = tick && start && !busy_reg;
    assign rise_t   = tick && busy_reg && t_reg[0] && (t_reg != TICK_W'(CSLD_TICKS));
    assign fall_t   = tick && busy_reg && !t_reg[0];
    assign end_t    = tick && busy_reg && (t_reg == TICK_W'(CSLD_TICKS));
    assign sample_t = rise_t && (t_reg >= TICK_W'(ADC_SAMPLE_FIRST));
    assign done     = end_t;
    assign rx_word  = rx_sh_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg  <= 1'b0;
            port_reg  <= 1'b0;
            t_reg     <= '0;
            tx_sh_reg <= '0;
            rx_sh_reg <= '0;
        end else if (launch) begin
            busy_reg  <= 1'b1;
            port_reg  <= port;
            t_reg     <= TICK_W'(1);
            // Bit 15 goes straight to the pin; the shifter holds the remaining bits.
            tx_sh_reg <= {tx_word[FRAME_BITS-2:0], 1'b0};
            rx_sh_reg <= '0;
        end else if (tick && busy_reg) begin
            t_reg <= end_t ? '0 : t_reg + TICK_W'(1);
            if (end_t) begin
                busy_reg <= 1'b0;
            end
            if (fall_t) begin
                tx_sh_reg <= {tx_sh_reg[FRAME_BITS-2:0], 1'b0};
            end
            if (sample_t) begin
                rx_sh_reg <= {rx_sh_reg[DATA_BITS-2:0], sdo};
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic sck_reg;
        logic csld_reg;
        logic sdin_reg;
        logic own;

        assign own = busy_reg && (port_reg == 1'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sck_reg  <= 1'b0;
                csld_reg <= 1'b1;
                sdin_reg <= 1'b0;
            end else if (launch && (port == 1'(gi))) begin
                csld_reg <= 1'b0;
                sdin_reg <= tx_word[FRAME_BITS-1];
            end else if (own) begin
                if (rise_t) begin
                    sck_reg <= 1'b1;
                end
                if (fall_t) begin
                    sck_reg  <= 1'b0;
                    sdin_reg <= tx_sh_reg[FRAME_BITS-1];
                end
                if (end_t) begin
                    csld_reg <= 1'b1;
                    sdin_reg <= 1'b0;
                end
            end
        end

        assign sck[gi]  = sck_reg;
        assign csld[gi] = csld_reg;
        assign sdin[gi] = sdin_reg;
    end

endmodule

// File: rtl/adda_serial_ctrl.sv
// Continuous ADC-to-DAC loopback: alternates an ADC read frame on port 1 with a DAC
// write frame on port 2, separated by idle gaps, holding the last complete ADC sample.
module adda_serial_ctrl
    import adda_pkg::*;
#(
    parameter int         CLK_DIV   = 8,
    parameter logic [3:0] ADC_CFG   = 4'b1101,
    parameter int         GAP_TICKS = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SDOUT,
    output logic SCK1,
    output logic SDIN1,
    output logic CSLD1,
    output logic SCK2,
    output logic SDIN2,
    output logic CSLD2
);

    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    adda_state_t           state_reg;
    logic                  dac_next_reg;
    logic [GAP_W-1:0]      gap_reg;
    logic [DATA_BITS-1:0]  sample_reg;
    logic [1:0]            sdo_sync_reg;

    logic                  tick;
    logic                  done;
    logic                  start;
    logic [DATA_BITS-1:0]  rx_word;
    logic [FRAME_BITS-1:0] tx_word;
    logic [1:0]            sck;
    logic [1:0]            csld;
    logic [1:0]            sdin;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sdo_sync_reg <= '0;
        end else begin
            sdo_sync_reg <= {sdo_sync_reg[0], SDOUT};
        end
    end

    assign start   = (state_reg == GAP) && (gap_reg == GAP_W'(GAP_TICKS));
    assign tx_word = dac_next_reg ? dac_frame_word(sample_reg) : adc_frame_word(ADC_CFG);

    // Reset behaves as if the closing tick of a frame had just passed, so the first
    // CSLD1 fall lands on the GAP_TICKS-th tick after release; between frames the
    // closing tick restarts the gap count from zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= GAP;
            dac_next_reg <= 1'b0;
            gap_reg      <= GAP_W'(1);
            sample_reg   <= '0;
        end else if (tick) begin
            case (state_reg)
                GAP: begin
                    if (gap_reg == GAP_W'(GAP_TICKS)) begin
                        state_reg <= dac_next_reg ? DAC_XFER : ADC_XFER;
                    end else begin
                        gap_reg <= gap_reg + GAP_W'(1);
                    end
                end
                ADC_XFER: begin
                    if (done) begin
                        sample_reg   <= rx_word;
                        state_reg    <= GAP;
                        gap_reg      <= '0;
                        dac_next_reg <= 1'b1;
                    end
                end
                DAC_XFER: begin
                    if (done) begin
                        state_reg    <= GAP;
                        gap_reg      <= '0;
                        dac_next_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= GAP;
                end
            endcase
        end
    end

    adda_spi_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (CLK),
        .rst_n   (RST_N),
        .start   (start),
        .port    (dac_next_reg),
        .tx_word (tx_word),
        .sdo     (sdo_sync_reg[1]),
        .tick    (tick),
        .done    (done),
        .rx_word (rx_word),
        .sck     (sck),
        .csld    (csld),
        .sdin    (sdin)
    );

    assign SCK1  = sck[0];
    assign CSLD1 = csld[0];
    assign SDIN1 = sdin[0];
    assign SCK2  = sck[1];
    assign CSLD2 = csld[1];
    assign SDIN2 = sdin[1];

endmodule

// File: tb/tb_adda_serial_ctrl.sv
// Directed bench: instance 0 at CLK_DIV=8, instance 1 at CLK_DIV=2, each with an ADC
// model on port 1 and a DAC capture model on port 2.
module tb_adda_serial_ctrl;

    logic CLK = 1'b0;
    logic RST_N;
    logic sdout [2];
    logic sck1 [2];
    logic sdin1 [2];
    logic csld1 [2];
    logic sck2 [2];
    logic sdin2 [2];
    logic csld2 [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [11:0] adc_code [2];
    logic [15:0] cfg_sh [2];
    logic [15:0] cfg_word [2];
    logic [15:0] dac_sh [2];
    logic [15:0] dac_word [2];
    int adc_n [2];
    int dac_n [2];
    int adc_frames [2];
    int dac_frames [2];
    int adc_pulses [2];
    int dac_pulses [2];
    int sck1_last [2];
    int sck1_per [2];
    int sck2_last [2];
    int sck2_per [2];
    int csld1_fall [2];
    int csld1_low [2];
    int csld2_fall [2];
    int csld2_low [2];
    int adc_period [2];
    int viol [2];

    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        adda_serial_ctrl #(
            .CLK_DIV   (gi == 0 ? 8 : 2),
            .ADC_CFG   (4'b1101),
            .GAP_TICKS (4)
        ) u_dut (
            .CLK   (CLK),
            .RST_N (RST_N),
            .SDOUT (sdout[gi]),
            .SCK1  (sck1[gi]),
            .SDIN1 (sdin1[gi]),
            .CSLD1 (csld1[gi]),
            .SCK2  (sck2[gi]),
            .SDIN2 (sdin2[gi]),
            .CSLD2 (csld2[gi])
        );

        // ADC model: presents the next data bit 1 ns after each SCK1 rise.
        initial forever begin
            @(negedge csld1[gi]);
            adc_n[gi] = 0;
            cfg_sh[gi] = '0;
            sdout[gi] = 1'b0;
            if (csld1_fall[gi] != 0) adc_period[gi] = cyc - csld1_fall[gi];
            csld1_fall[gi] = cyc;
        end
        initial forever begin
            @(posedge csld1[gi]);
            csld1_low[gi] = cyc - csld1_fall[gi];
            cfg_word[gi] = cfg_sh[gi];
            adc_pulses[gi] = adc_n[gi];
            adc_frames[gi]++;
        end
        initial forever begin
            @(posedge sck1[gi]);
            adc_n[gi]++;
            cfg_sh[gi] = {cfg_sh[gi][14:0], sdin1[gi]};
            if (adc_n[gi] > 1) sck1_per[gi] = cyc - sck1_last[gi];
            sck1_last[gi] = cyc;
            #1;
            if (adc_n[gi] >= 4 && adc_n[gi] < 16) sdout[gi] = adc_code[gi][15 - adc_n[gi]];
            else sdout[gi] = 1'b0;
        end

        // DAC model: shifts SDIN2 at SCK2 rises, latches on CSLD2 rise.
        initial forever begin
            @(negedge csld2[gi]);
            dac_n[gi] = 0;
            dac_sh[gi] = '0;
            csld2_fall[gi] = cyc;
        end
        initial forever begin
            @(posedge csld2[gi]);
            csld2_low[gi] = cyc - csld2_fall[gi];
            dac_word[gi] = dac_sh[gi];
            dac_pulses[gi] = dac_n[gi];
            dac_frames[gi]++;
        end
        initial forever begin
            @(posedge sck2[gi]);
            dac_n[gi]++;
            dac_sh[gi] = {dac_sh[gi][14:0], sdin2[gi]};
            if (dac_n[gi] > 1) sck2_per[gi] = cyc - sck2_last[gi];
            sck2_last[gi] = cyc;
        end

        initial forever begin
            @(negedge CLK);
            if ((!csld1[gi] && sck2[gi]) || (!csld2[gi] && sck1[gi]) ||
                (!csld1[gi] && !csld2[gi]) || (csld1[gi] && sck1[gi]) ||
                (csld2[gi] && sck2[gi]))
                viol[gi]++;
        end
    end

    task automatic wait_frames(input int inst, input bit dac, input int target, input string tag);
        int n = 0;
        while (((dac ? dac_frames[inst] : adc_frames[inst]) < target) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            failures++;
            $display("FAIL timeout_%s: frame count %0d, required %0d", tag,
                     dac ? dac_frames[inst] : adc_frames[inst], target);
        end
    endtask

    task automatic test_reset();
        int rel;
        int n = 0;
        #3 RST_N = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({csld1[i], csld2[i], sck1[i], sck2[i], sdin1[i], sdin2[i]} !== 6'b110000) begin
                failures++;
                $display("FAIL reset_pins inst%0d: got %b, required 110000", i,
                         {csld1[i], csld2[i], sck1[i], sck2[i], sdin1[i], sdin2[i]});
            end
        end
        checks++;
        if (g_dut[0].u_dut.sample_reg !== 12'h000) begin
            failures++;
            $display("FAIL reset_sample: got %h, required 000", g_dut[0].u_dut.sample_reg);
        end
        rel = cyc;
        RST_N = 1'b1;
        while (csld1[0] !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (csld1_fall[0] - rel != 32) begin
            failures++;
            $display("FAIL first_csld1_fall: %0d cycles after release, required 32", csld1_fall[0] - rel);
        end
        checks++;
        if (csld1_fall[1] - rel != 8) begin
            failures++;
            $display("FAIL first_csld1_fall_div2: %0d cycles after release, required 8", csld1_fall[1] - rel);
        end
    endtask

    task automatic test_adc_dac_word();
        wait_frames(0, 1'b0, adc_frames[0] + 1, "adc_a5c");
        checks++;
        if (cfg_word[0] !== 16'hD000) begin
            failures++;
            $display("FAIL adc_cfg_word: got %h, required d000", cfg_word[0]);
        end
        wait_frames(0, 1'b1, dac_frames[0] + 1, "dac_a5c");
        checks++;
        if (dac_word[0] !== 16'h0A5C) begin
            failures++;
            $display("FAIL dac_word_a5c: got %h, required 0a5c", dac_word[0]);
        end
    endtask

    task automatic test_timing();
        checks++;
        if (sck1_per[0] != 16 || sck2_per[0] != 16) begin
            failures++;
            $display("FAIL sck_period: sck1 %0d sck2 %0d, required 16", sck1_per[0], sck2_per[0]);
        end
        checks++;
        if (adc_pulses[0] != 16 || dac_pulses[0] != 16) begin
            failures++;
            $display("FAIL sck_pulses: adc %0d dac %0d, required 16", adc_pulses[0], dac_pulses[0]);
        end
        checks++;
        if (csld1_low[0] != 264 || csld2_low[0] != 264) begin
            failures++;
            $display("FAIL csld_low: csld1 %0d csld2 %0d, required 264", csld1_low[0], csld2_low[0]);
        end
        checks++;
        if (viol[0] != 0) begin
            failures++;
            $display("FAIL port_isolation: %0d bad cycles, required 0", viol[0]);
        end
    endtask

    task automatic test_sequential();
        logic [11:0] codes [3];
        codes[0] = 12'h000;
        codes[1] = 12'hFFF;
        codes[2] = 12'h800;
        for (int k = 0; k < 3; k++) begin
            adc_code[0] = codes[k];
            wait_frames(0, 1'b1, dac_frames[0] + 1, "dac_seq");
            checks++;
            if (dac_word[0] !== {4'h0, codes[k]}) begin
                failures++;
                $display("FAIL dac_word_seq%0d: got %h, required %h", k, dac_word[0], {4'h0, codes[k]});
            end
        end
        checks++;
        if (adc_period[0] != 608) begin
            failures++;
            $display("FAIL cycle_period: got %0d, required 608", adc_period[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        adc_code[0] = 12'h3C7;
        while ((csld1[0] !== 1'b0 || adc_n[0] < 6) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL timeout_adc_bit5: adc_n %0d, required 6", adc_n[0]);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if ({csld1[0], csld2[0], sck1[0], sck2[0], sdin1[0], sdin2[0]} !== 6'b110000) begin
            failures++;
            $display("FAIL abort_pins: got %b, required 110000",
                     {csld1[0], csld2[0], sck1[0], sck2[0], sdin1[0], sdin2[0]});
        end
        checks++;
        if (g_dut[0].u_dut.sample_reg !== 12'h000) begin
            failures++;
            $display("FAIL abort_sample: got %h, required 000", g_dut[0].u_dut.sample_reg);
        end
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        wait_frames(0, 1'b1, dac_frames[0] + 1, "dac_after_abort");
        checks++;
        if (dac_word[0] !== 16'h03C7) begin
            failures++;
            $display("FAIL dac_after_abort: got %h, required 03c7", dac_word[0]);
        end
    endtask

    task automatic test_clk_div2();
        wait_frames(1, 1'b1, dac_frames[1] + 1, "div2_sync");
        adc_code[1] = 12'h6B1;
        wait_frames(1, 1'b1, dac_frames[1] + 1, "div2_dac");
        checks++;
        if (dac_word[1] !== 16'h06B1 || cfg_word[1] !== 16'hD000) begin
            failures++;
            $display("FAIL div2_words: dac %h cfg %h, required 06b1 d000", dac_word[1], cfg_word[1]);
        end
        checks++;
        if (sck1_per[1] != 4 || sck2_per[1] != 4 || dac_pulses[1] != 16) begin
            failures++;
            $display("FAIL div2_sck: sck1 %0d sck2 %0d pulses %0d, required 4 4 16",
                     sck1_per[1], sck2_per[1], dac_pulses[1]);
        end
        checks++;
        if (csld1_low[1] != 66 || csld2_low[1] != 66 || adc_period[1] != 152) begin
            failures++;
            $display("FAIL div2_timing: csld1 %0d csld2 %0d period %0d, required 66 66 152",
                     csld1_low[1], csld2_low[1], adc_period[1]);
        end
        checks++;
        if (viol[1] != 0) begin
            failures++;
            $display("FAIL div2_isolation: %0d bad cycles, required 0", viol[1]);
        end
    endtask

    initial begin
        adc_code[0] = 12'hA5C;
        adc_code[1] = 12'hA5C;
        sdout[0] = 1'b0;
        sdout[1] = 1'b0;
        RST_N = 1'b1;
        test_reset();
        test_adc_dac_word();
        test_timing();
        test_sequential();
        test_reset_mid();
        test_clk_div2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
